// File: rtl/demux_buf_pkg.sv
// Shared constants for demux_buf: FIFO geometry, counter width and select encoding.
// Pure declarations; no timing behaviour.
// Not applicable: no handshake lives here.
package demux_buf_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 16;
    localparam int PTR_W      = 1;
    localparam int OCC_W      = 2;

    localparam logic [1:0]       SEL_A    = 2'd0;
    localparam logic [OCC_W-1:0] OCC_FULL = 2'd2;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // Only the all-zero code reaches port A; every other code steers to B.
    function automatic port_e port_of(input logic [1:0] ctrl);
        return (ctrl == SEL_A) ? PORT_A : PORT_B;
    endfunction

endpackage

// File: rtl/demux_buf_fifo.sv
// Two-entry per-port FIFO with registered storage and a head-of-queue output.
// Latency: a pushed word is visible at dout one cycle later; pop takes effect at the clock edge.
// Backpressure: full refuses pushes; pop without valid is ignored.
module demux_buf_fifo
    import demux_buf_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             do_push;
    logic             do_pop;

    assign valid   = (occ != '0);
    assign full    = (occ == OCC_FULL);
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Push and pop together leave the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/demux_buf.sv
// Steers one valid/ready stream into two independently buffered ports (A when ctrl==0, else B).
// Latency: one cycle from input handshake to port valid; DEMUX_BUF_CNT_EN adds per-port delivery counters.
// Backpressure: in_ready follows only the selected port's FIFO, so a stalled port never blocks the other.
module demux_buf
    import demux_buf_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       ctrl,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data
`ifdef DEMUX_BUF_CNT_EN
    ,
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt
`endif
);

    port_e dst;
    logic  a_full;
    logic  b_full;
    logic  in_fire;
    logic  a_push;
    logic  b_push;
    logic  a_pop;
    logic  b_pop;

    assign dst      = port_of(ctrl);
    assign in_ready = (dst == PORT_A) ? ~a_full : ~b_full;
    assign in_fire  = in_valid & in_ready;
    assign a_push   = in_fire & (dst == PORT_A);
    assign b_push   = in_fire & (dst == PORT_B);
    assign a_pop    = a_valid & a_ready;
    assign b_pop    = b_valid & b_ready;

    demux_buf_fifo #(.WIDTH(WIDTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .push  (a_push),
        .pop   (a_pop),
        .din   (in_data),
        .dout  (a_data),
        .valid (a_valid),
        .full  (a_full)
    );

    demux_buf_fifo #(.WIDTH(WIDTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .push  (b_push),
        .pop   (b_pop),
        .din   (in_data),
        .dout  (b_data),
        .valid (b_valid),
        .full  (b_full)
    );

`ifdef DEMUX_BUF_CNT_EN
    // Free-running delivery counters; natural 16-bit wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_cnt <= '0;
            b_cnt <= '0;
        end else begin
            if (a_pop) a_cnt <= a_cnt + 1'b1;
            if (b_pop) b_cnt <= b_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_buf.sv
// Directed bench for demux_buf with a per-port scoreboard of accepted words.
module tb_demux_buf;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   ctrl;
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] a_data;
    logic         b_valid;
    logic         b_ready;
    logic [W-1:0] b_data;
`ifdef DEMUX_BUF_CNT_EN
    logic [15:0]  a_cnt;
    logic [15:0]  b_cnt;
    int           a_pops;
    int           b_pops;
`endif

    int errors = 0;
    int checks = 0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic         a_hold;
    logic         b_hold;
    logic [W-1:0] a_prev;
    logic [W-1:0] b_prev;

    always #5 clk = ~clk;

    demux_buf #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .ctrl     (ctrl),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data)
`ifdef DEMUX_BUF_CNT_EN
        ,
        .a_cnt    (a_cnt),
        .b_cnt    (b_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: at the falling edge score pops/pushes about to happen, then return just after the rising edge.
    task automatic step();
        logic [W-1:0] e;
        @(negedge clk);
        if (rst) begin
            qa.delete();
            qb.delete();
            a_hold = 1'b0;
            b_hold = 1'b0;
`ifdef DEMUX_BUF_CNT_EN
            a_pops = 0;
            b_pops = 0;
`endif
        end else begin
            if (a_hold) begin
                check("a_hold_valid", 32'(a_valid), 32'd1);
                check("a_hold_data", 32'(a_data), 32'(a_prev));
            end
            if (b_hold) begin
                check("b_hold_valid", 32'(b_valid), 32'd1);
                check("b_hold_data", 32'(b_data), 32'(b_prev));
            end
            if (a_valid && a_ready) begin
                if (qa.size() == 0) check("a_unexpected", 32'(a_data), 32'hDEAD);
                else begin
                    e = qa.pop_front();
                    check("a_order", 32'(a_data), 32'(e));
                end
`ifdef DEMUX_BUF_CNT_EN
                a_pops++;
`endif
            end
            if (b_valid && b_ready) begin
                if (qb.size() == 0) check("b_unexpected", 32'(b_data), 32'hDEAD);
                else begin
                    e = qb.pop_front();
                    check("b_order", 32'(b_data), 32'(e));
                end
`ifdef DEMUX_BUF_CNT_EN
                b_pops++;
`endif
            end
            if (in_valid && in_ready) begin
                if (ctrl == 2'd0) qa.push_back(in_data);
                else qb.push_back(in_data);
            end
            a_hold = a_valid && !a_ready;
            b_hold = b_valid && !b_ready;
            a_prev = a_data;
            b_prev = b_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [W-1:0] d);
        ctrl     = c;
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; ctrl = 2'd0;
        a_ready = 1'b0; b_ready = 1'b0;
        a_hold = 1'b0; b_hold = 1'b0; a_prev = '0; b_prev = '0;
        step(); step();
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_a_data", 32'(a_data), 32'd0);
        check("rst_b_data", 32'(b_data), 32'd0);
`ifdef DEMUX_BUF_CNT_EN
        check("rst_a_cnt", 32'(a_cnt), 32'd0);
        check("rst_b_cnt", 32'(b_cnt), 32'd0);
`endif
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single word to A.
        a_ready = 1'b1; b_ready = 1'b1;
        send(2'd0, 8'h11);
        check("a_first_valid", 32'(a_valid), 32'd1);
        check("a_first_data", 32'(a_data), 32'h11);
        check("a_first_b_idle", 32'(b_valid), 32'd0);
        step();
        check("a_drained", 32'(a_valid), 32'd0);

        // ctrl==3 still means port B.
        send(2'd3, 8'h22);
        check("b_sel3_valid", 32'(b_valid), 32'd1);
        check("b_sel3_a_idle", 32'(a_valid), 32'd0);
        check("b_sel3_data", 32'(b_data), 32'h22);
        step();
        check("b_drained", 32'(b_valid), 32'd0);

        // Fill A while stalled; B stays reachable.
        a_ready = 1'b0; b_ready = 1'b0;
        send(2'd0, 8'h31);
        send(2'd0, 8'h32);
        check("a_full_in_ready", 32'(in_ready), 32'd0);
        send(2'd0, 8'h3F);
        check("a_full_still", 32'(in_ready), 32'd0);
        ctrl = 2'd1;
        #1;
        check("b_open_in_ready", 32'(in_ready), 32'd1);
        send(2'd1, 8'h33);
        check("b_33_valid", 32'(b_valid), 32'd1);
        check("b_33_data", 32'(b_data), 32'h33);
        check("a_head_kept", 32'(a_data), 32'h31);

        // A full, consumer running, producer pushing every cycle.
        a_ready = 1'b1;
        ctrl = 2'd0; in_data = 8'h40; in_valid = 1'b1;
        #1;
        check("stream_first_refused", 32'(in_ready), 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'h40 + i);
            #1;
            check("stream_in_ready", 32'(in_ready), 32'd1);
            check("stream_a_valid", 32'(a_valid), 32'd1);
            step();
        end
        in_valid = 1'b0;
        b_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("stream_qa_empty", 32'(qa.size()), 32'd0);
        check("stream_qb_empty", 32'(qb.size()), 32'd0);
        check("stream_a_idle", 32'(a_valid), 32'd0);

        // Reset discards queued words on both ports.
        a_ready = 1'b0; b_ready = 1'b0;
        send(2'd0, 8'h51);
        send(2'd2, 8'h61);
        send(2'd0, 8'h52);
        send(2'd1, 8'h62);
        check("pre_rst_b_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rst_flush_a_valid", 32'(a_valid), 32'd0);
        check("rst_flush_b_valid", 32'(b_valid), 32'd0);
        check("rst_flush_in_ready_b", 32'(in_ready), 32'd1);
        ctrl = 2'd0;
        #1;
        check("rst_flush_in_ready_a", 32'(in_ready), 32'd1);
        a_ready = 1'b1; b_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("rst_flush_never_a", 32'(a_valid), 32'd0);
        check("rst_flush_never_b", 32'(b_valid), 32'd0);

`ifdef DEMUX_BUF_CNT_EN
        check("cnt_a_zero", 32'(a_cnt), 32'd0);
        begin
            int guard;
            guard = 0;
            ctrl = 2'd0; in_valid = 1'b1; a_ready = 1'b1;
            while (a_pops < 65537 && guard < 70000) begin
                in_data = 8'(guard);
                step();
                guard++;
            end
            in_valid = 1'b0; a_ready = 1'b0;
            check("cnt_pop_budget", 32'(a_pops), 32'd65537);
            check("cnt_a_wrap", 32'(a_cnt), 32'd1);
            check("cnt_b_unchanged", 32'(b_cnt), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_buf.md
DEMUX_BUF -- requirements
Module: demux_buf

Interface
REQ-001 Parameter WIDTH, default 8, data path width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  upstream word present.
REQ-005 in_ready  output  1  demux_buf accepts the upstream word this cycle.
REQ-006 in_data  input  WIDTH  upstream word.
REQ-007 ctrl  input  2  destination select: ctrl==0 selects port A; any nonzero value selects port B.
REQ-008 a_valid  output  1  port A word present.
REQ-009 a_ready  input  1  port A consumer takes the word.
REQ-010 a_data  output  WIDTH  port A word.
REQ-011 b_valid, b_ready, b_data: same as REQ-008..REQ-010, for port B.
REQ-012 a_cnt, b_cnt  output  16 each  words delivered per port; present only with DEMUX_BUF_CNT_EN.

Function
REQ-013 Each port SHALL own an independent 2-entry FIFO; the input handshake completes when in_valid and in_ready are both 1.
REQ-014 ctrl SHALL be sampled only in the handshake cycle; ctrl changes without a handshake have no effect.
REQ-015 in_ready SHALL be 1 exactly when the FIFO selected by the current ctrl holds fewer than 2 entries; it is combinational from ctrl and the FIFO state, and independent of in_valid.
REQ-016 A word accepted in cycle N SHALL appear at the head of its port no earlier than cycle N+1; with an empty FIFO the port's valid goes to 1 in cycle N+1.
REQ-017 Each port SHALL deliver words in acceptance order; words sent to different ports have no ordering relation.
REQ-018 A port pops one entry in each cycle where its valid and ready are both 1; its data holds stable while valid is 1 and ready is 0.
REQ-019 Simultaneous push and pop on one port SHALL leave its count unchanged; when the FIFO is full the push is refused, because in_ready is 0.
REQ-020 A stall on one port SHALL NOT block words destined for the other port.
REQ-021 FIFO pointers SHALL be 1 bit and wrap from 1 to 0; the count is 2 bits with range 0..2.
REQ-022 Without a handshake, port state changes only by pops.

Reset
REQ-023 While rst is 1 at a clock edge, both FIFOs SHALL empty: a_valid=b_valid=0, a_data=b_data=0, pointers=0, a_cnt=b_cnt=0.
REQ-024 Reset SHALL take priority over a handshake or pop in the same cycle; in-flight words are discarded.
REQ-025 in_ready SHALL read 1 in the first cycle after rst deasserts.

Configuration
REQ-026 With macro DEMUX_BUF_CNT_EN defined:
- a_cnt and b_cnt SHALL exist.
- Each counter increments by 1 on every pop of its port.
- Each counter wraps from 16'hFFFF to 0.
REQ-027 Without DEMUX_BUF_CNT_EN:
- The a_cnt and b_cnt ports and their counter logic SHALL be absent.
- All other behaviour is identical.

Structure
REQ-028 Package demux_buf_pkg SHALL hold FIFO_DEPTH=2, CNT_W=16 and the select encoding constant SEL_A=2'd0.
REQ-029 The per-port FIFO SHALL be sub-module demux_buf_fifo, instantiated twice.
- Ports: clk, rst, push, pop, din, dout, valid, full.

Verification
REQ-030 Reset, then in_data=8'h11, ctrl=0, in_valid=1 for one cycle, a_ready=1 -> a_valid=1 with a_data=8'h11 the next cycle; b_valid stays 0.
REQ-031 ctrl=2'd3, send 8'h22 -> word appears on port B only, confirming every nonzero ctrl selects port B.
REQ-032 a_ready=0, send 3 words to A back-to-back:
- in_ready=0 after the 2nd word.
- With ctrl=1 in the next cycle, in_ready=1 and 8'h33 is accepted to B.
REQ-033 Port A full, a_ready=1 while pushing a word to A every cycle -> in_ready is 0 in the first cycle, because the FIFO is full.
- Thereafter, one push and one pop per cycle.
- The count stays at 2.
- Output order matches input order.
REQ-034 Assert rst with two words queued on each port -> next cycle a_valid=b_valid=0, in_ready=1, and the queued words are never delivered.
REQ-035 With DEMUX_BUF_CNT_EN, 65537 pops on port A -> a_cnt=1, b_cnt unchanged.
